// File: rtl/jala_pkg.sv
// Shared constants for the Jala integer core: datapath widths and the
// writeback grant encoding used by the register-file write scheduler.
package jala_pkg;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_LSU = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational; the last
// granted source is remembered so the other one wins the next tie.
module rr_arbiter2
    import jala_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_alu,
    input  logic req_lsu,
    output logic grant_alu,
    output logic grant_lsu
);

    logic last_grant;

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (req_alu && req_lsu) begin
            grant_alu = (last_grant == GNT_LSU);
            grant_lsu = (last_grant == GNT_ALU);
        end else begin
            grant_alu = req_alu;
            grant_lsu = req_lsu;
        end
    end

    // Starting at LSU lets the ALU take the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_LSU;
        end else if (grant_alu || grant_lsu) begin
            last_grant <= grant_lsu ? GNT_LSU : GNT_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/LSU writebacks, keeps
// a per-register pending-write scoreboard and raises the issue stall.
module regfile_wb_scheduler
    import jala_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int NUM_REGS = jala_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_has_rd,
    output logic              issue_stall,
    input  logic              alu_wb_valid,
    input  logic [ADDR_W-1:0] alu_wb_rd,
    input  logic [XLEN_P-1:0] alu_wb_data,
    output logic              alu_wb_ready,
    input  logic              lsu_wb_valid,
    input  logic [ADDR_W-1:0] lsu_wb_rd,
    input  logic [XLEN_P-1:0] lsu_wb_data,
    output logic              lsu_wb_ready,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [XLEN_P-1:0] rf_write_data,
    output logic              err_spurious_wb
);

    // Handshake: a source raises valid with rd/data and holds all three
    // stable until ready; a beat transfers on valid && ready. Ready is a
    // function of valid (the grant), valid never looks at ready.
    logic                grant_alu;
    logic                grant_lsu;
    logic                any_grant;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] eff_busy;
    logic                issue_set;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_alu   (alu_wb_valid),
        .req_lsu   (lsu_wb_valid),
        .grant_alu (grant_alu),
        .grant_lsu (grant_lsu)
    );

    assign any_grant     = grant_alu || grant_lsu;
    assign alu_wb_ready  = grant_alu;
    assign lsu_wb_ready  = grant_lsu;
    assign rf_write_addr = grant_lsu ? lsu_wb_rd : alu_wb_rd;
    assign rf_write_data = grant_lsu ? lsu_wb_data : alu_wb_data;
    assign rf_write_en   = any_grant && (rf_write_addr != '0);

    // A register being written this cycle is bypassed by the register
    // file, so it no longer blocks a reader.
    always_comb begin
        eff_busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            eff_busy[r] = busy[r] && !(rf_write_en && rf_write_addr == ADDR_W'(r));
        end
    end

    assign issue_stall = issue_valid && (eff_busy[issue_rs1] || eff_busy[issue_rs2] ||
                                         (issue_has_rd && eff_busy[issue_rd]));
    assign issue_set   = issue_valid && !issue_stall && issue_has_rd && (issue_rd != '0);

    // Ordering gives set priority over clear, and flush priority over both.
    always_comb begin
        busy_next = busy;
        if (rf_write_en) begin
            busy_next[rf_write_addr] = 1'b0;
        end
        if (issue_set) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy            <= '0;
            err_spurious_wb <= 1'b0;
        end else begin
            busy <= busy_next;
            if (rf_write_en && !busy[rf_write_addr] && !flush) begin
                err_spurious_wb <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rd;
    logic        issue_has_rd;
    logic        issue_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        lsu_wb_valid;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        lsu_wb_ready;
    logic        rf_write_en;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        err_spurious_wb;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    regfile_wb_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_rd        (issue_rd),
        .issue_has_rd    (issue_has_rd),
        .issue_stall     (issue_stall),
        .alu_wb_valid    (alu_wb_valid),
        .alu_wb_rd       (alu_wb_rd),
        .alu_wb_data     (alu_wb_data),
        .alu_wb_ready    (alu_wb_ready),
        .lsu_wb_valid    (lsu_wb_valid),
        .lsu_wb_rd       (lsu_wb_rd),
        .lsu_wb_data     (lsu_wb_data),
        .lsu_wb_ready    (lsu_wb_ready),
        .rf_write_en     (rf_write_en),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .err_spurious_wb (err_spurious_wb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: busy set, who was granted last, sticky error
    bit [31:0] m_busy;
    int        m_last;
    bit        m_err;
    bit        m_ga, m_gl, m_we, m_stall, m_set;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit [31:0] m_eff;

    always_comb begin
        m_ga = 1'b0;
        m_gl = 1'b0;
        if (alu_wb_valid && lsu_wb_valid) begin
            if (m_last == 1) m_ga = 1'b1;
            else             m_gl = 1'b1;
        end else begin
            m_ga = alu_wb_valid;
            m_gl = lsu_wb_valid;
        end
        m_rd   = m_gl ? lsu_wb_rd : alu_wb_rd;
        m_data = m_gl ? lsu_wb_data : alu_wb_data;
        m_we   = (m_ga || m_gl) && (m_rd != 0);
        m_eff  = '0;
        for (int r = 1; r < 32; r++) begin
            m_eff[r] = m_busy[r] && !(m_we && int'(m_rd) == r);
        end
        m_stall = issue_valid && (m_eff[issue_rs1] || m_eff[issue_rs2] ||
                                  (issue_has_rd && m_eff[issue_rd]));
        m_set   = issue_valid && !m_stall && issue_has_rd && (issue_rd != 0);
    end

    always @(posedge clk) begin
        if (reset) begin
            m_busy = '0;
            m_last = 1;
            m_err  = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (m_ga) m_last = 0;
            if (m_gl) m_last = 1;
            if (m_we && !m_busy[m_rd] && !flush) m_err = 1'b1;
            if (m_we) m_busy[m_rd] = 1'b0;
            if (m_set) m_busy[issue_rd] = 1'b1;
            if (flush) m_busy = '0;
        end
    end

    // scoreboard compare: every cycle once the model state is defined
    always @(negedge clk) begin
        if (chk_en) begin
            chk("alu_wb_ready", 32'(alu_wb_ready), 32'(m_ga));
            chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(m_gl));
            chk("rf_write_en", 32'(rf_write_en), 32'(m_we));
            chk("issue_stall", 32'(issue_stall), 32'(m_stall));
            chk("err_spurious_wb", 32'(err_spurious_wb), 32'(m_err));
            if (m_we) begin
                chk("rf_write_addr", 32'(rf_write_addr), 32'(m_rd));
                chk("rf_write_data", rf_write_data, m_data);
            end
        end
    end

    // driver tasks
    task automatic idle();
        flush        = 1'b0;
        issue_valid  = 1'b0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_rd     = '0;
        issue_has_rd = 1'b0;
        alu_wb_valid = 1'b0;
        alu_wb_rd    = '0;
        alu_wb_data  = '0;
        lsu_wb_valid = 1'b0;
        lsu_wb_rd    = '0;
        lsu_wb_data  = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        next();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic has_rd);
        issue_valid  = 1'b1;
        issue_rs1    = rs1;
        issue_rs2    = rs2;
        issue_rd     = rd;
        issue_has_rd = has_rd;
    endtask

    function automatic logic [4:0] pick_rd();
        logic [4:0] r;
        if ($urandom_range(0, 99) < 70) begin
            for (int k = 0; k < 8; k++) begin
                r = 5'($urandom_range(1, 15));
                if (m_busy[r]) return r;
            end
        end
        return 5'($urandom_range(0, 15));
    endfunction

    logic [4:0] exp_addr[4];
    logic [4:0] a_rd, l_rd;
    bit         a_fire, l_fire;

    initial begin
        idle();
        reset = 1'b1;
        next();
        next();
        reset = 1'b0;

        // reset state, then ALU alone
        @(negedge clk);
        chk("rst_stall", 32'(issue_stall), 32'd0);
        chk("rst_err", 32'(err_spurious_wb), 32'd0);
        chk("rst_we", 32'(rf_write_en), 32'd0);
        next();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("alu5_ready", 32'(alu_wb_ready), 32'd1);
        chk("alu5_we", 32'(rf_write_en), 32'd1);
        chk("alu5_addr", 32'(rf_write_addr), 32'd5);
        chk("alu5_data", rf_write_data, 32'hDEADBEEF);
        next();
        do_reset();

        // both sources contend: alternate starting with ALU
        exp_addr[0] = 5'd1; exp_addr[1] = 5'd9; exp_addr[2] = 5'd2; exp_addr[3] = 5'd10;
        a_rd = 5'd1; l_rd = 5'd9;
        for (int i = 0; i < 4; i++) begin
            alu_wb_valid = 1'b1; alu_wb_rd = a_rd; alu_wb_data = 32'(a_rd) + 32'h100;
            lsu_wb_valid = 1'b1; lsu_wb_rd = l_rd; lsu_wb_data = 32'(l_rd) + 32'h200;
            @(negedge clk);
            chk("rr_alu_ready", 32'(alu_wb_ready), 32'(i % 2 == 0));
            chk("rr_lsu_ready", 32'(lsu_wb_ready), 32'(i % 2 == 1));
            chk("rr_addr", 32'(rf_write_addr), 32'(exp_addr[i]));
            next();
            if (i % 2 == 0) a_rd = a_rd + 5'd1;
            else            l_rd = l_rd + 5'd1;
        end
        do_reset();

        // RAW hazard on r7 resolved by a same-cycle LSU writeback
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        @(negedge clk);
        chk("iss7_stall", 32'(issue_stall), 32'd0);
        next();
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("raw7_stall", 32'(issue_stall), 32'd1);
        next();
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'h0000_0777;
        @(negedge clk);
        chk("byp7_stall", 32'(issue_stall), 32'd0);
        chk("byp7_we", 32'(rf_write_en), 32'd1);
        next();
        lsu_wb_valid = 1'b0;
        @(negedge clk);
        chk("clr7_stall", 32'(issue_stall), 32'd0);
        next();
        idle();

        // set beats clear on r3
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        next();
        issue(5'd0, 5'd0, 5'd3, 1'b1);
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
        @(negedge clk);
        chk("sc3_stall", 32'(issue_stall), 32'd0);
        next();
        idle();
        issue(5'd3, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("sc3_busy", 32'(issue_stall), 32'd1);
        next();
        idle();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h34;
        next();
        idle();
        @(negedge clk);
        chk("sc3_err", 32'(err_spurious_wb), 32'd0);
        next();

        // rd=0 acknowledged but not written; spurious write to r8
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h1234;
        @(negedge clk);
        chk("r0_ready", 32'(alu_wb_ready), 32'd1);
        chk("r0_we", 32'(rf_write_en), 32'd0);
        next();
        idle();
        @(negedge clk);
        chk("r0_err", 32'(err_spurious_wb), 32'd0);
        next();
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd8; lsu_wb_data = 32'h88;
        @(negedge clk);
        chk("sp8_we", 32'(rf_write_en), 32'd1);
        chk("sp8_addr", 32'(rf_write_addr), 32'd8);
        next();
        idle();
        @(negedge clk);
        chk("sp8_err", 32'(err_spurious_wb), 32'd1);
        for (int i = 0; i < 3; i++) next();
        @(negedge clk);
        chk("sp8_sticky", 32'(err_spurious_wb), 32'd1);
        next();
        do_reset();
        @(negedge clk);
        chk("sp8_cleared", 32'(err_spurious_wb), 32'd0);
        next();

        // flush beats a same-cycle issue
        issue(5'd0, 5'd0, 5'd2, 1'b1); next();
        issue(5'd0, 5'd0, 5'd4, 1'b1); next();
        issue(5'd0, 5'd0, 5'd6, 1'b1); next();
        issue(5'd0, 5'd0, 5'd10, 1'b1);
        flush = 1'b1;
        next();
        idle();
        issue(5'd2, 5'd4, 5'd6, 1'b1);
        @(negedge clk);
        chk("fl_246", 32'(issue_stall), 32'd0);
        next();
        idle();
        issue(5'd10, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("fl_10", 32'(issue_stall), 32'd0);
        next();
        idle();

        // mid-stream reset clears busy and re-arms ALU priority
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0;
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        next();
        do_reset();
        alu_wb_valid = 1'b1; alu_wb_rd = 5'd0;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0;
        issue(5'd9, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("mr_alu_wins", 32'(alu_wb_ready), 32'd1);
        chk("mr_lsu_held", 32'(lsu_wb_ready), 32'd0);
        chk("mr_stall", 32'(issue_stall), 32'd0);
        next();
        do_reset();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            a_fire = alu_wb_valid && m_ga;
            l_fire = lsu_wb_valid && m_gl;
            next();
            if (reset) begin
                reset = 1'b0;
                a_fire = 1'b1;
                l_fire = 1'b1;
            end
            if (!alu_wb_valid || a_fire) begin
                alu_wb_valid = ($urandom_range(0, 99) < 55);
                alu_wb_rd    = pick_rd();
                alu_wb_data  = $urandom;
            end
            if (!lsu_wb_valid || l_fire) begin
                lsu_wb_valid = ($urandom_range(0, 99) < 45);
                lsu_wb_rd    = pick_rd();
                lsu_wb_data  = $urandom;
            end
            issue_valid  = ($urandom_range(0, 99) < 70);
            issue_rs1    = 5'($urandom_range(0, 15));
            issue_rs2    = 5'($urandom_range(0, 15));
            issue_rd     = 5'($urandom_range(0, 15));
            issue_has_rd = ($urandom_range(0, 99) < 75);
            flush        = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 299) == 0) begin
                reset        = 1'b1;
                alu_wb_valid = 1'b0;
                lsu_wb_valid = 1'b0;
            end
        end
        idle();
        reset = 1'b0;
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
